// File: rtl/eda_region_flag_buffer.sv
// Region-maxima flag buffer: holds an M x N flag bitmap that starts as all ones.
// A running per-region AND of comparator results is committed to the strobed
// cells, either overwriting them or ANDing into them. The bitmap is read out
// one row per beat over a valid/ready port, with a last-row marker, a popcount
// of the set flags, and a sticky error for compare/commit traffic that arrives
// during a readout.

`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif

module eda_region_flag_buffer #(
    parameter int M       = `CFG_M,
    parameter int N       = `CFG_N,
    parameter int I_WIDTH = `CFG_I_WIDTH,
    parameter int CNT_W   = $clog2(M*N+1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      cmp_valid,
    input  logic                      compare_out,
    input  logic                      region_commit,
    input  logic                      commit_mode,
    input  logic                      iterated_all,
    input  logic [M-1:0][N-1:0]       strb_value,
    input  logic                      rd_start,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [N-1:0]              rd_row,
    output logic [I_WIDTH-1:0]        rd_row_idx,
    output logic                      rd_last,
    output logic                      busy,
    output logic [CNT_W-1:0]          flag_count,
    output logic                      count_valid,
    output logic                      err_overlap
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [M-1:0][N-1:0]  flags;
    logic                 region_ok;
    logic [CNT_W-1:0]     acc;

    logic                 beat;
    logic                 commit_ok;
    logic                 cmp_ok;
    logic                 eff;
    logic [CNT_W-1:0]     row_pop;

    function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) begin
            c = c + CNT_W'(v[k]);
        end
        return c;
    endfunction

    // Row mux, handshake decode and the commit/compare qualifiers.
    always_comb begin
        rd_row    = flags[rd_row_idx];
        rd_valid  = (state == READ);
        busy      = (state == READ);
        rd_last   = rd_valid && (rd_row_idx == I_WIDTH'(M-1));
        beat      = rd_valid && rd_ready;
        row_pop   = popcount(rd_row);
        commit_ok = region_commit && !iterated_all && (state == IDLE);
        cmp_ok    = cmp_valid && !iterated_all && (state == IDLE);
        // A compare landing in the commit cycle still counts toward the region.
        eff       = region_ok && (cmp_valid ? compare_out : 1'b1);
    end

    // Readout FSM next state; clear always returns to IDLE.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (rd_start)        state_next = READ;
                READ: if (beat && rd_last) state_next = IDLE;
                default:                   state_next = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flag matrix, region accumulator, readout index/popcount and error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags       <= '1;
            region_ok   <= 1'b1;
            rd_row_idx  <= '0;
            acc         <= '0;
            flag_count  <= '0;
            count_valid <= 1'b0;
            err_overlap <= 1'b0;
        end else if (clear) begin
            flags       <= '1;
            region_ok   <= 1'b1;
            rd_row_idx  <= '0;
            acc         <= '0;
            flag_count  <= '0;
            count_valid <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            if (commit_ok) begin
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (strb_value[i][j]) begin
                            flags[i][j] <= commit_mode ? (flags[i][j] & eff) : eff;
                        end
                    end
                end
                region_ok   <= 1'b1;
                count_valid <= 1'b0;
            end else if (cmp_ok && !compare_out) begin
                region_ok <= 1'b0;
            end

            // The matrix is frozen while reading; late traffic is flagged.
            if ((state == READ) && (cmp_valid || region_commit)) begin
                err_overlap <= 1'b1;
            end

            if ((state == IDLE) && rd_start) begin
                rd_row_idx  <= '0;
                acc         <= '0;
                count_valid <= 1'b0;
            end

            if (beat) begin
                if (rd_last) begin
                    flag_count  <= acc + row_pop;
                    count_valid <= 1'b1;
                    rd_row_idx  <= '0;
                    acc         <= '0;
                end else begin
                    acc        <= acc + row_pop;
                    rd_row_idx <= rd_row_idx + I_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_eda_region_flag_buffer.sv
// Directed bench for eda_region_flag_buffer with a 4x4 bitmap.

module tb_eda_region_flag_buffer;

    localparam int M = 4;
    localparam int N = 4;
    localparam int I_WIDTH = 2;
    localparam int CNT_W = $clog2(M*N+1);

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 cmp_valid = 1'b0;
    logic                 compare_out = 1'b0;
    logic                 region_commit = 1'b0;
    logic                 commit_mode = 1'b0;
    logic                 iterated_all = 1'b0;
    logic [M-1:0][N-1:0]  strb_value = '0;
    logic                 rd_start = 1'b0;
    logic                 rd_valid;
    logic                 rd_ready = 1'b0;
    logic [N-1:0]         rd_row;
    logic [I_WIDTH-1:0]   rd_row_idx;
    logic                 rd_last;
    logic                 busy;
    logic [CNT_W-1:0]     flag_count;
    logic                 count_valid;
    logic                 err_overlap;

    int checks = 0;
    int failures = 0;

    eda_region_flag_buffer #(.M(M), .N(N), .I_WIDTH(I_WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .cmp_valid(cmp_valid),
        .compare_out(compare_out), .region_commit(region_commit),
        .commit_mode(commit_mode), .iterated_all(iterated_all),
        .strb_value(strb_value), .rd_start(rd_start), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_row(rd_row), .rd_row_idx(rd_row_idx),
        .rd_last(rd_last), .busy(busy), .flag_count(flag_count),
        .count_valid(count_valid), .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_commit(input logic [15:0] strb, input logic mode,
                             input logic cv, input logic co);
        region_commit = 1'b1;
        commit_mode   = mode;
        strb_value    = strb;
        cmp_valid     = cv;
        compare_out   = co;
        step();
        region_commit = 1'b0;
        commit_mode   = 1'b0;
        strb_value    = '0;
        cmp_valid     = 1'b0;
        compare_out   = 1'b0;
    endtask

    // Full readout with rd_ready held high; returns the captured bitmap.
    task automatic readout(output logic [15:0] img, output int beats,
                           output int lasts, output int last_beat, output int cycles);
        img = '0; beats = 0; lasts = 0; last_beat = -1; cycles = 0;
        rd_ready = 1'b1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        while (rd_valid && cycles < 20) begin
            img[int'(rd_row_idx)*4 +: 4] = rd_row;
            beats++;
            if (rd_last) begin
                lasts++;
                last_beat = beats;
            end
            cycles++;
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rd_row_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", rd_row_idx); end
        checks++; if (rd_last !== 1'b0) begin failures++; $display("FAIL reset_rd_last got=%b exp=0", rd_last); end
        checks++; if (flag_count !== 5'd0) begin failures++; $display("FAIL reset_flag_count got=%0d exp=0", flag_count); end
        checks++; if (count_valid !== 1'b0) begin failures++; $display("FAIL reset_count_valid got=%b exp=0", count_valid); end
        checks++; if (err_overlap !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overlap); end
        checks++; if (rd_row !== 4'hF) begin failures++; $display("FAIL reset_row0 got=%h exp=f", rd_row); end
    endtask

    task automatic test_full_readout();
        logic [15:0] img; int beats, lasts, lb, cyc;
        readout(img, beats, lasts, lb, cyc);
        checks++; if (img !== 16'hFFFF) begin failures++; $display("FAIL t1_image got=%h exp=ffff", img); end
        checks++; if (beats !== 4) begin failures++; $display("FAIL t1_beats got=%0d exp=4", beats); end
        checks++; if (lasts !== 1 || lb !== 4) begin failures++; $display("FAIL t1_last got=%0d@%0d exp=1@4", lasts, lb); end
        checks++; if (cyc !== 4) begin failures++; $display("FAIL t1_back_to_back_cycles got=%0d exp=4", cyc); end
        checks++; if (flag_count !== 5'd16) begin failures++; $display("FAIL t1_flag_count got=%0d exp=16", flag_count); end
        checks++; if (count_valid !== 1'b1) begin failures++; $display("FAIL t1_count_valid got=%b exp=1", count_valid); end
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL t1_idle got=%b%b exp=00", busy, rd_valid); end
    endtask

    task automatic test_commit_overwrite();
        logic [15:0] img; int beats, lasts, lb, cyc;
        do_clear();
        cmp_valid = 1'b1; compare_out = 1'b1; step();
        compare_out = 1'b0; step();
        cmp_valid = 1'b0;
        do_commit(16'h0060, 1'b0, 1'b0, 1'b0);
        readout(img, beats, lasts, lb, cyc);
        checks++; if (img !== 16'hFF9F) begin failures++; $display("FAIL t2_image got=%h exp=ff9f", img); end
        checks++; if (flag_count !== 5'd14) begin failures++; $display("FAIL t2_flag_count got=%0d exp=14", flag_count); end
        // Fresh region: no compares, so eff=1 restores cell (1,1).
        do_commit(16'h0020, 1'b0, 1'b0, 1'b0);
        checks++; if (count_valid !== 1'b0) begin failures++; $display("FAIL t2_commit_clears_cv got=%b exp=0", count_valid); end
        readout(img, beats, lasts, lb, cyc);
        checks++; if (img !== 16'hFFBF) begin failures++; $display("FAIL t2_fresh_region got=%h exp=ffbf", img); end
        checks++; if (flag_count !== 5'd15) begin failures++; $display("FAIL t2_flag_count2 got=%0d exp=15", flag_count); end
    endtask

    task automatic test_same_cycle_and();
        logic [15:0] img; int beats, lasts, lb, cyc;
        do_clear();
        do_commit(16'h0060, 1'b0, 1'b1, 1'b0);
        readout(img, beats, lasts, lb, cyc);
        checks++; if (img !== 16'hFF9F) begin failures++; $display("FAIL t3_same_cycle got=%h exp=ff9f", img); end
        do_commit(16'h0061, 1'b1, 1'b0, 1'b0);
        readout(img, beats, lasts, lb, cyc);
        checks++; if (img !== 16'hFF9F) begin failures++; $display("FAIL t3_and_mode got=%h exp=ff9f", img); end
        checks++; if (flag_count !== 5'd14) begin failures++; $display("FAIL t3_flag_count got=%0d exp=14", flag_count); end
    endtask

    task automatic test_stall();
        logic [3:0] er [4];
        bit pat [10];
        int exp_idx, beats;
        er = '{4'hE, 4'hD, 4'hB, 4'h7};
        pat = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        do_clear();
        do_commit(16'h8421, 1'b0, 1'b1, 1'b0);
        rd_ready = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
        exp_idx = 0; beats = 0;
        for (int c = 0; c < 10; c++) begin
            if (rd_valid) begin
                rd_ready = pat[c];
                checks++; if (int'(rd_row_idx) !== exp_idx) begin failures++; $display("FAIL t4_idx c=%0d got=%0d exp=%0d", c, rd_row_idx, exp_idx); end
                if (exp_idx < 4) begin
                    checks++; if (rd_row !== er[exp_idx]) begin failures++; $display("FAIL t4_row c=%0d got=%h exp=%h", c, rd_row, er[exp_idx]); end
                end
                if (pat[c]) begin beats++; exp_idx++; end
            end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (beats !== 4) begin failures++; $display("FAIL t4_beats got=%0d exp=4", beats); end
        checks++; if (flag_count !== 5'd12) begin failures++; $display("FAIL t4_flag_count got=%0d exp=12", flag_count); end
    endtask

    task automatic test_overlap();
        logic [15:0] img; int beats, lasts, lb, cyc;
        do_clear();
        rd_ready = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b1;
        region_commit = 1'b1; strb_value = 16'hFFFF; cmp_valid = 1'b1; compare_out = 1'b0;
        step();
        region_commit = 1'b0; strb_value = '0; cmp_valid = 1'b0; rd_start = 1'b0;
        checks++; if (err_overlap !== 1'b1) begin failures++; $display("FAIL t5_err got=%b exp=1", err_overlap); end
        checks++; if (rd_valid !== 1'b1 || rd_row_idx !== 2'd0) begin failures++; $display("FAIL t5_hold got=%b/%0d exp=1/0", rd_valid, rd_row_idx); end
        img = '0; beats = 0; rd_ready = 1'b1;
        while (rd_valid && beats < 10) begin
            img[int'(rd_row_idx)*4 +: 4] = rd_row;
            beats++;
            step();
        end
        rd_ready = 1'b0;
        checks++; if (img !== 16'hFFFF || beats !== 4) begin failures++; $display("FAIL t5_frozen got=%h/%0d exp=ffff/4", img, beats); end
        // region_ok must not have been cleared by the ignored compare.
        do_commit(16'h0001, 1'b0, 1'b0, 1'b0);
        readout(img, beats, lasts, lb, cyc);
        checks++; if (flag_count !== 5'd16) begin failures++; $display("FAIL t5_region_ok got=%0d exp=16", flag_count); end
        do_clear();
        checks++; if (err_overlap !== 1'b0 || count_valid !== 1'b0 || flag_count !== 5'd0) begin failures++; $display("FAIL t5_clear got=%b%b/%0d exp=00/0", err_overlap, count_valid, flag_count); end
    endtask

    task automatic test_clear_abort();
        logic [15:0] img; int beats, lasts, lb, cyc, guard;
        do_clear();
        rd_ready = 1'b1; rd_start = 1'b1; step(); rd_start = 1'b0;
        guard = 0;
        while (rd_row_idx != 2'd1 && guard < 10) begin step(); guard++; end
        clear = 1'b1; step(); clear = 1'b0; rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t6_abort got=%b%b exp=00", rd_valid, busy); end
        checks++; if (count_valid !== 1'b0 || rd_row_idx !== 2'd0 || rd_last !== 1'b0) begin failures++; $display("FAIL t6_abort_state got=%b/%0d/%b exp=0/0/0", count_valid, rd_row_idx, rd_last); end
        iterated_all = 1'b1;
        do_commit(16'hFFFF, 1'b0, 1'b1, 1'b0);
        cmp_valid = 1'b1; compare_out = 1'b0; step(); cmp_valid = 1'b0;
        readout(img, beats, lasts, lb, cyc);
        checks++; if (img !== 16'hFFFF || beats !== 4) begin failures++; $display("FAIL t6_iterated got=%h/%0d exp=ffff/4", img, beats); end
        iterated_all = 1'b0;
        do_commit(16'h0001, 1'b0, 1'b0, 1'b0);
        readout(img, beats, lasts, lb, cyc);
        checks++; if (flag_count !== 5'd16) begin failures++; $display("FAIL t6_region_ok got=%0d exp=16", flag_count); end
    endtask

    initial begin
        reset_n = 1'b0;
        step();
        step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_full_readout();
        test_commit_overwrite();
        test_same_cycle_and();
        test_stall();
        test_overlap();
        test_clear_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eda_region_flag_buffer.md
Name: eda_region_flag_buffer

Overview:
- Parametrised successor to the region-maxima output matrix.
- Holds an M x N flag bitmap, initialised to all-ones. A running per-region AND of comparator results is committed to every strobed pixel, in either overwrite or accumulate (AND) mode.
- Adds a row-serial valid/ready readout port with last-row marker, a popcount of set flags, and overlap error detection.
- Sits between the compare/iteration datapath and the result DMA/host read path.

Parameters:
- M, `CFG_M, image rows.
- N, `CFG_N, image columns; readout row width.
- I_WIDTH, `CFG_I_WIDTH, row index width (must hold M-1).
- CNT_W, $clog2(M*N+1), popcount width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- clear  in  1  synchronous re-init for a new image; highest priority
- cmp_valid  in  1  compare_out valid this cycle
- compare_out  in  1  1 = neighbour does not beat the region value
- region_commit  in  1  end of current region; write flags to strobed cells
- commit_mode  in  1  0 = overwrite, 1 = AND into existing flag
- iterated_all  in  1  iteration finished; suppresses cmp/commit
- strb_value  in  [M-1:0][N-1:0]  cells belonging to the committed region
- rd_start  in  1  begin row readout
- rd_valid  out  1  row beat valid
- rd_ready  in  1  consumer accepts beat
- rd_row  out  N  flags of row rd_row_idx
- rd_row_idx  out  I_WIDTH  current row index
- rd_last  out  1  beat is row M-1
- busy  out  1  readout in progress
- flag_count  out  CNT_W  number of set flags, valid when count_valid
- count_valid  out  1  flag_count final
- err_overlap  out  1  sticky: cmp/commit arrived during readout

Behaviour:
Reset values:
- matrix all 1; region_ok=1; state IDLE.
- rd_valid=0, rd_row_idx=0, rd_last=0, busy=0.
- flag_count=0, count_valid=0, err_overlap=0.

region_ok (running AND):
- clear -> 1.
- Else region_commit (accepted) -> 1 on the next cycle, so the next region starts fresh.
- Else cmp_valid & !iterated_all & !compare_out & state==IDLE -> 0.

Commit (region_commit & !iterated_all & state==IDLE & !clear):
- eff = region_ok & (cmp_valid ? compare_out : 1). A compare arriving in the same cycle as the commit is included.
- For each cell with strb_value[i][j]=1, the new value is eff (commit_mode=0) or cell & eff (commit_mode=1).
- Cells with strb_value[i][j]=0 are unchanged.
- The written value is visible on the next cycle.
- A commit also clears count_valid, since the matrix changed.

Readout FSM, states IDLE and READ:
- IDLE + rd_start & !clear -> READ. Next cycle: rd_valid=1, rd_row_idx=0, busy=1, accumulator=0, count_valid=0.
- In READ, rd_row = matrix row rd_row_idx (combinational mux). The matrix is frozen during READ.
- A beat transfers when rd_valid & rd_ready. On transfer, accumulator += popcount(rd_row).
- rd_valid, rd_row and rd_row_idx are held stable until the beat transfers.
- rd_last = rd_valid & (rd_row_idx==M-1).
- Transfer with rd_last: -> IDLE; rd_valid=0; busy=0; flag_count=accumulator+popcount(row); count_valid=1 (level) until clear, commit or next rd_start.
- Transfer without rd_last: rd_row_idx+1 next cycle, rd_valid stays 1. Back-to-back beats are allowed, giving M beats in M cycles when rd_ready is held high.
- rd_start while in READ is ignored.
- cmp_valid or region_commit while in READ are ignored (matrix and region_ok unchanged) and set err_overlap.

clear:
- Any state -> IDLE next cycle.
- Matrix all 1, region_ok=1.
- rd_valid=0, busy=0, rd_row_idx=0.
- flag_count=0, count_valid=0, err_overlap=0.
- An in-flight readout is aborted; no rd_last is emitted.

Other boundaries:
- iterated_all=1 blocks commit and the region_ok update, but readout still operates.
- M=1: the first beat has rd_last=1.
- The accumulator must not overflow: CNT_W holds M*N.

Test Plan:
1. M=4,N=4, reset, rd_start, rd_ready=1 -> 4 beats, rows 4'hF, rd_last on beat 4 only, flag_count=16, count_valid=1.
2. strb_value = cells (1,1),(1,2); compare_out=1,0 over 2 cmp_valid cycles; commit mode 0 -> cells (1,1),(1,2)=0, others 1; readout flag_count=14; next region region_ok=1.
3. Commit with cmp_valid=1, compare_out=0 in the same cycle, region_ok=1 -> strobed cells written 0. Then mode 1 commit eff=1 on the same cells -> they stay 0 (AND).
4. rd_ready toggling 1,0,0,1 during readout -> rd_row/rd_row_idx stable while stalled, no beat lost or duplicated, total beats=4.
5. region_commit and cmp_valid pulsed during READ -> matrix unchanged, err_overlap=1. Subsequent clear -> err_overlap=0, matrix all 1.
6. clear asserted at beat 2 of readout -> rd_valid=0 and busy=0 next cycle, count_valid=0. Then iterated_all=1 with a commit -> matrix unchanged.
